uart_rx_param: RTL and testbench

Parametrised, oversampling UART receiver that generalises the existing fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority voting against noise; parity, framing and overrun detection.
- Break handling.
- Small receive FIFO behind a valid/ready handshake.
- Sits between the board RX pin and any byte consumer (command parser, loopback, display logic).

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_param.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    // Clock cycles per oversampling tick, truncated.
    function automatic int calc_div(input int clock, input int baud, input int os);
        return int'(longint'(clock) / (longint'(baud) * longint'(os)));
    endfunction

    // True when the received parity bit agrees with the payload. Narrow
    // payloads are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_ok(input logic [8:0] data, input logic pbit,
                                       input parity_e mode);
        case (mode)
            PAR_ODD:  return (^data ^ pbit) == 1'b1;
            PAR_EVEN: return (^data ^ pbit) == 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO with full/empty flags.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: storage is not reset; the count register alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority voting, error flags, break
// handling and a small FWFT receive FIFO.
module uart_rx_param #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int      DIV      = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int      SCNT_W   = $clog2(OVERSAMPLE);
    localparam int      M        = OVERSAMPLE / 2;
    localparam int      WORD_W   = DATA_BITS + 2;
    localparam parity_e PAR_MODE = parity_e'(PARITY);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_param: clock too slow for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
        $error("uart_rx_param: PARITY must be 0..2 and STOP_BITS 1..2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_param: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [1:0]           r_sync;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [SCNT_W-1:0]    r_scnt;
    logic [1:0]           r_samp;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_stop_cnt;
    logic                 r_overrun;
    rx_state_t            r_state;

    rx_state_t            w_state_next;
    logic                 w_rx_s, w_tick, w_wrap, w_decide, w_bit, w_frame_now;
    logic                 w_push, w_shift_en, w_par_chk, w_stop_low, w_stop_adv;
    logic                 w_pop, w_fifo_full, w_fifo_empty;
    logic [WORD_W-1:0]    w_head;

    assign w_rx_s      = r_sync[1];
    assign w_tick      = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_wrap      = w_tick && (r_scnt == SCNT_W'(OVERSAMPLE - 1));
    assign w_decide    = w_tick && (r_scnt == SCNT_W'(M + 1));
    assign w_bit       = maj3(r_samp[0], r_samp[1], w_rx_s);
    assign w_frame_now = r_frame_err | ~w_bit;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rx};
    end

    // Free-running oversampling tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_div_cnt <= '0;
        else     r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and per-cycle control strobes.
    // NOTE: every output gets a default first so no path leaves a value held (no latches).
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_shift_en   = 1'b0;
        w_par_chk    = 1'b0;
        w_stop_low   = 1'b0;
        w_stop_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rx_s) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_decide && w_bit) w_state_next = ST_IDLE;
                else if (w_wrap)       w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_shift_en = w_decide;
                if (w_wrap && (r_bit_cnt == 4'(DATA_BITS)))
                    w_state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                w_par_chk = w_decide;
                if (w_wrap) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                w_stop_low = w_decide && !w_bit;
                if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                    // The final stop bit ends at its decision point.
                    if (w_decide) begin
                        w_push       = 1'b1;
                        w_state_next = (w_frame_now && (r_shift == '0)) ? ST_BREAK_WAIT
                                                                        : ST_IDLE;
                    end
                end else begin
                    w_stop_adv = w_wrap;
                end
            end
            ST_BREAK_WAIT: begin
                if (w_tick && w_rx_s) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bit-level datapath: sample counter, vote samples, shifter and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt      <= '0;
            r_samp      <= 2'b11;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_stop_cnt  <= 1'b0;
        end else begin
            if (w_state_next != r_state) r_scnt <= '0;
            else if (w_tick)             r_scnt <= w_wrap ? '0 : r_scnt + 1'b1;

            if (w_tick && (r_scnt == SCNT_W'(M - 1))) r_samp[0] <= w_rx_s;
            if (w_tick && (r_scnt == SCNT_W'(M)))     r_samp[1] <= w_rx_s;

            if ((w_state_next == ST_DATA) && (r_state != ST_DATA)) r_bit_cnt <= '0;
            else if (w_shift_en)                                     r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};

            if ((w_state_next == ST_START) && (r_state != ST_START)) begin
                r_par_err   <= 1'b0;
                r_frame_err <= 1'b0;
            end else begin
                if (w_par_chk)  r_par_err   <= ~parity_ok(9'(r_shift), w_bit, PAR_MODE);
                if (w_stop_low) r_frame_err <= 1'b1;
            end

            if ((w_state_next == ST_STOP) && (r_state != ST_STOP)) r_stop_cnt <= 1'b0;
            else if (w_stop_adv)                                     r_stop_cnt <= 1'b1;
        end
    end

    // Overrun pulse: a completed frame found the FIFO full with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_overrun <= 1'b0;
        else     r_overrun <= w_push && w_fifo_full && !w_pop;
    end

    assign w_pop = rx_valid && rx_ready;

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({w_frame_now, r_par_err, r_shift}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign rx_valid      = !w_fifo_empty;
    assign rx_data       = w_head[DATA_BITS-1:0];
    assign rx_parity_err = w_head[DATA_BITS];
    assign rx_frame_err  = w_head[DATA_BITS+1];
    assign overrun       = r_overrun;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 8N2) at DIV = 10,
// 160 clocks per bit, checked through a shared expected-word queue.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 160;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       par_flip;
        logic       stop_low;
        int         glitch_pos;
        logic [9:0] exp_word;   // {frame_err, parity_err, data}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_l     [3];
    logic       ready_l  [3];
    logic [7:0] data_o   [3];
    logic       pe_o     [3];
    logic       fe_o     [3];
    logic       valid_o  [3];
    logic       ovr_o    [3];
    logic       busy_o   [3];

    int par_mode [3] = '{0, 2, 0};
    int nstop    [3] = '{1, 1, 2};

    int         sel = 0;
    logic       m_valid, m_ready, m_pe, m_fe, m_ovr, m_busy;
    logic [7:0] m_data;

    logic [9:0] sb [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         busy_cnt = 0;
    int         valid_cnt = 0;
    int         ovr_cnt = 0;
    vec_t       vecs [9];

    always #5 clk = ~clk;

    uart_rx_param #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
        .clk(clk), .rst(rst), .rx(rx_l[0]), .rx_data(data_o[0]),
        .rx_parity_err(pe_o[0]), .rx_frame_err(fe_o[0]), .rx_valid(valid_o[0]),
        .rx_ready(ready_l[0]), .overrun(ovr_o[0]), .busy(busy_o[0]));

    uart_rx_param #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
        .clk(clk), .rst(rst), .rx(rx_l[1]), .rx_data(data_o[1]),
        .rx_parity_err(pe_o[1]), .rx_frame_err(fe_o[1]), .rx_valid(valid_o[1]),
        .rx_ready(ready_l[1]), .overrun(ovr_o[1]), .busy(busy_o[1]));

    uart_rx_param #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_8n2 (
        .clk(clk), .rst(rst), .rx(rx_l[2]), .rx_data(data_o[2]),
        .rx_parity_err(pe_o[2]), .rx_frame_err(fe_o[2]), .rx_valid(valid_o[2]),
        .rx_ready(ready_l[2]), .overrun(ovr_o[2]), .busy(busy_o[2]));

    always_comb begin
        m_valid = valid_o[sel];
        m_ready = ready_l[sel];
        m_data  = data_o[sel];
        m_pe    = pe_o[sel];
        m_fe    = fe_o[sel];
        m_ovr   = ovr_o[sel];
        m_busy  = busy_o[sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every accepted head word is compared with the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got 0x%0h with nothing expected",
                             {m_fe, m_pe, m_data});
                end else begin
                    check("rx_word", {22'd0, m_fe, m_pe, m_data}, {22'd0, sb.pop_front()});
                end
            end
            if (m_busy)  busy_cnt++;
            if (m_valid) valid_cnt++;
            if (m_ovr)   ovr_cnt++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input logic glitch);
        rx_l[sel] = v;
        if (glitch) begin
            hold(75);
            rx_l[sel] = ~v;
            hold(10);
            rx_l[sel] = v;
            hold(75);
        end else begin
            hold(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic last_stop_low, input int glitch_pos);
        logic p;
        drive_bit(1'b0, glitch_pos == 0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_pos == i + 1);
        if (par_mode[sel] != 0) begin
            p = (par_mode[sel] == 1) ? ~^d : ^d;
            drive_bit(p ^ par_flip, 1'b0);
        end
        for (int s = 0; s < nstop[sel]; s++)
            drive_bit(!(last_stop_low && (s == nstop[sel] - 1)), 1'b0);
        rx_l[sel] = 1'b1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog_timeout: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, -1, 10'h0A5};
        vecs[1] = '{1, 8'h3C, 1'b1, 1'b0, -1, 10'h13C};
        vecs[2] = '{1, 8'h3C, 1'b0, 1'b0, -1, 10'h03C};
        vecs[3] = '{2, 8'h55, 1'b0, 1'b1, -1, 10'h255};
        vecs[4] = '{0, 8'hF0, 1'b0, 1'b0,  4, 10'h0F0};
        vecs[5] = '{1, 8'hFF, 1'b0, 1'b0, -1, 10'h0FF};
        vecs[6] = '{0, 8'h00, 1'b0, 1'b0, -1, 10'h000};
        vecs[7] = '{2, 8'h81, 1'b0, 1'b0, -1, 10'h081};
        vecs[8] = '{1, 8'h5A, 1'b1, 1'b1, -1, 10'h35A};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_l[k]    = 1'b1;
            ready_l[k] = 1'b1;
        end
        hold(5);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check($sformatf("reset_outputs_inst%0d", k),
                  {19'd0, m_valid, m_busy, m_ovr, m_pe, m_fe, m_data}, 32'd0);
        end
        rst = 1'b0;
        hold(BIT_CLKS);

        // Table of single frames.
        ovr_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            sel       = vecs[i].inst;
            busy_cnt  = 0;
            valid_cnt = 0;
            sb.push_back(vecs[i].exp_word);
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_low, vecs[i].glitch_pos);
            hold(2 * BIT_CLKS);
            check($sformatf("vec%0d_received", i), sb.size(), 0);
            check($sformatf("vec%0d_valid_cycles", i), valid_cnt, 1);
            if (i == 0)
                check("vec0_busy_about_9p5_bits", (busy_cnt >= 1500) && (busy_cnt <= 1580), 1);
        end
        check("table_no_overrun", ovr_cnt, 0);

        // Short glitch on an idle line.
        sel       = 0;
        valid_cnt = 0;
        rx_l[0]   = 1'b0;
        hold(3);
        rx_l[0]   = 1'b1;
        hold(BIT_CLKS);
        check("glitch_busy_cleared", m_busy, 1'b0);
        hold(BIT_CLKS);
        check("glitch_no_word", valid_cnt, 0);

        // Break on the 8N2 instance: one zero word, then silence until rx rises.
        sel     = 2;
        sb.push_back(10'h200);
        rx_l[2] = 1'b0;
        hold(15 * BIT_CLKS);
        check("break_word_seen", sb.size(), 0);
        check("break_busy_in_wait", m_busy, 1'b1);
        hold(5 * BIT_CLKS);
        rx_l[2] = 1'b1;
        hold(2 * BIT_CLKS);
        check("break_back_to_idle", m_busy, 1'b0);
        sb.push_back(10'h081);
        send_frame(8'h81, 1'b0, 1'b0, -1);
        hold(2 * BIT_CLKS);
        check("after_break_received", sb.size(), 0);

        // Overrun: five back-to-back frames into a 4-deep FIFO with no consumer.
        sel        = 0;
        ready_l[0] = 1'b0;
        ovr_cnt    = 0;
        for (int b = 1; b <= 5; b++) begin
            if (b <= 4) sb.push_back({2'b00, 8'(b)});
            send_frame(8'(b), 1'b0, 1'b0, -1);
        end
        hold(BIT_CLKS);
        check("overrun_pulses", ovr_cnt, 1);
        check("overrun_fifo_holds", m_valid, 1'b1);
        ready_l[0] = 1'b1;
        hold(4);
        check("drain_empty_after_4", m_valid, 1'b0);
        check("drain_all_words", sb.size(), 0);

        // Asynchronous reset in the middle of a frame, with a word pending.
        ready_l[0] = 1'b0;
        sb.push_back(10'h03A);
        send_frame(8'h3A, 1'b0, 1'b0, -1);
        hold(2 * BIT_CLKS);
        check("pre_reset_word_pending", m_valid, 1'b1);
        rx_l[0] = 1'b0;
        hold(BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
        check("pre_reset_busy", m_busy, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {19'd0, m_valid, m_busy, m_ovr, m_pe, m_fe, m_data}, 32'd0);
        sb.delete();
        rx_l[0] = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(2 * BIT_CLKS);
        ready_l[0] = 1'b1;
        valid_cnt  = 0;
        sb.push_back(10'h012);
        send_frame(8'h12, 1'b0, 1'b0, -1);
        hold(2 * BIT_CLKS);
        check("post_reset_received", sb.size(), 0);
        check("post_reset_one_word", valid_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
